// File: rtl/vliw_pkg.sv
// rtl/vliw_pkg.sv - shared constants and lane-slicing helpers for the VLIW register file
package vliw_pkg;

    localparam int VLIW_LANES = 3;
    localparam int VLIW_WIDTH = 64;
    localparam int VLIW_NREGS = 16;

    // Low bit of lane's field inside a flattened LANES*w vector
    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

    // High bit of lane's field inside a flattened LANES*w vector
    function automatic int lane_hi(input int lane, input int w);
        return lane * w + w - 1;
    endfunction

endpackage

// File: rtl/vliw_rf_scoreboard.sv
// rtl/vliw_rf_scoreboard.sv - pending-write scoreboard and RAW hazard flags (macro VLIW_RF_BYPASS_EN)
import vliw_pkg::*;

module vliw_rf_scoreboard #(
    parameter int LANES = VLIW_LANES,
    parameter int NREGS = VLIW_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_flush,
    input  logic [LANES-1:0]    i_rd_valid,
    input  logic [LANES*AW-1:0] i_rd_src1,
    input  logic [LANES*AW-1:0] i_rd_src2,
    input  logic [LANES-1:0]    i_iss_valid,
    input  logic [LANES*AW-1:0] i_iss_dest,
    input  logic [LANES-1:0]    i_wr_en,
    input  logic [LANES*AW-1:0] i_wr_dest,
    output logic [LANES-1:0]    o_hazard
);

    logic [NREGS-1:0] r_pending;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_next;
    logic [NREGS-1:0] w_eff;
    logic [AW-1:0]    w_src1 [LANES];
    logic [AW-1:0]    w_src2 [LANES];
    logic [AW-1:0]    w_iss  [LANES];
    logic [AW-1:0]    w_wrd  [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_slice
        assign w_src1[g] = i_rd_src1[lane_lo(g, AW) +: AW];
        assign w_src2[g] = i_rd_src2[lane_lo(g, AW) +: AW];
        assign w_iss[g]  = i_iss_dest[lane_lo(g, AW) +: AW];
        assign w_wrd[g]  = i_wr_dest[lane_lo(g, AW) +: AW];
    end

    // Clear masks from writeback, set masks from issue; set wins, flush wipes everything
    always_comb begin
        w_clr = '0;
        w_set = '0;
        for (int l = 0; l < LANES; l++) begin
            if (i_wr_en[l])    w_clr[w_wrd[l]] = 1'b1;
            if (i_iss_valid[l]) w_set[w_iss[l]] = 1'b1;
        end
        w_next = i_flush ? '0 : ((r_pending & ~w_clr) | w_set);
    end

    // Pending vector register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_next;
        end
    end

    // Hazard per lane; with bypass, a register retiring this cycle is already safe to read
    always_comb begin
`ifdef VLIW_RF_BYPASS_EN
        w_eff = r_pending & ~w_clr;
`else
        w_eff = r_pending;
`endif
        o_hazard = '0;
        for (int l = 0; l < LANES; l++) begin
            o_hazard[l] = i_rd_valid[l] & (w_eff[w_src1[l]] | w_eff[w_src2[l]]);
        end
    end

endmodule

// File: rtl/vliw_regfile_n.sv
// rtl/vliw_regfile_n.sv - LANES-wide register file with registered reads and scoreboard (macro VLIW_RF_BYPASS_EN)
import vliw_pkg::*;

module vliw_regfile_n #(
    parameter int LANES = VLIW_LANES,
    parameter int WIDTH = VLIW_WIDTH,
    parameter int NREGS = VLIW_NREGS
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_flush,
    input  logic [LANES-1:0]              i_rd_valid,
    input  logic [LANES*$clog2(NREGS)-1:0] i_rd_src1,
    input  logic [LANES*$clog2(NREGS)-1:0] i_rd_src2,
    input  logic [LANES-1:0]              i_iss_valid,
    input  logic [LANES*$clog2(NREGS)-1:0] i_iss_dest,
    input  logic [LANES-1:0]              i_wr_en,
    input  logic [LANES*$clog2(NREGS)-1:0] i_wr_dest,
    input  logic [LANES*WIDTH-1:0]        i_wr_data,
    output logic [LANES*WIDTH-1:0]        o_src1_data,
    output logic [LANES*WIDTH-1:0]        o_src2_data,
    output logic [LANES*$clog2(NREGS)-1:0] o_src1_idx,
    output logic [LANES*$clog2(NREGS)-1:0] o_src2_idx,
    output logic [LANES-1:0]              o_out_valid,
    output logic [LANES-1:0]              o_hazard
);

    localparam int AW = $clog2(NREGS);

    logic [WIDTH-1:0]       r_regs [NREGS];
    logic [LANES*WIDTH-1:0] r_src1_data;
    logic [LANES*WIDTH-1:0] r_src2_data;
    logic [LANES*AW-1:0]    r_src1_idx;
    logic [LANES*AW-1:0]    r_src2_idx;
    logic [LANES-1:0]       r_out_valid;

    logic [AW-1:0]    w_src1 [LANES];
    logic [AW-1:0]    w_src2 [LANES];
    logic [AW-1:0]    w_wrd  [LANES];
    logic [WIDTH-1:0] w_wrdat[LANES];
    logic [WIDTH-1:0] w_rd1  [LANES];
    logic [WIDTH-1:0] w_rd2  [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_slice
        assign w_src1[g]  = i_rd_src1[lane_lo(g, AW) +: AW];
        assign w_src2[g]  = i_rd_src2[lane_lo(g, AW) +: AW];
        assign w_wrd[g]   = i_wr_dest[lane_lo(g, AW) +: AW];
        assign w_wrdat[g] = i_wr_data[lane_lo(g, WIDTH) +: WIDTH];
    end

    // Storage write; later (higher) lanes overwrite earlier ones on a shared destination
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (i_wr_en[l]) r_regs[w_wrd[l]] <= w_wrdat[l];
            end
        end
    end

    // Operand selection: storage, optionally overridden by the highest-lane same-cycle write
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_rd1[l] = r_regs[w_src1[l]];
            w_rd2[l] = r_regs[w_src2[l]];
`ifdef VLIW_RF_BYPASS_EN
            for (int j = 0; j < LANES; j++) begin
                if (i_wr_en[j] && (w_wrd[j] == w_src1[l])) w_rd1[l] = w_wrdat[j];
                if (i_wr_en[j] && (w_wrd[j] == w_src2[l])) w_rd2[l] = w_wrdat[j];
            end
`endif
        end
    end

    // Read output flops; data and indices hold when a lane is idle or flushed
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_src1_data <= '0;
            r_src2_data <= '0;
            r_src1_idx  <= '0;
            r_src2_idx  <= '0;
            r_out_valid <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (i_rd_valid[l] && !i_flush) begin
                    r_src1_data[l*WIDTH +: WIDTH] <= w_rd1[l];
                    r_src2_data[l*WIDTH +: WIDTH] <= w_rd2[l];
                    r_src1_idx[l*AW +: AW]        <= w_src1[l];
                    r_src2_idx[l*AW +: AW]        <= w_src2[l];
                    r_out_valid[l]                <= 1'b1;
                end else begin
                    r_out_valid[l]                <= 1'b0;
                end
            end
        end
    end

    assign o_src1_data = r_src1_data;
    assign o_src2_data = r_src2_data;
    assign o_src1_idx  = r_src1_idx;
    assign o_src2_idx  = r_src2_idx;
    assign o_out_valid = r_out_valid;

    vliw_rf_scoreboard #(
        .LANES (LANES),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_flush     (i_flush),
        .i_rd_valid  (i_rd_valid),
        .i_rd_src1   (i_rd_src1),
        .i_rd_src2   (i_rd_src2),
        .i_iss_valid (i_iss_valid),
        .i_iss_dest  (i_iss_dest),
        .i_wr_en     (i_wr_en),
        .i_wr_dest   (i_wr_dest),
        .o_hazard    (o_hazard)
    );

endmodule

// File: tb/tb_vliw_regfile_n.sv
// tb/tb_vliw_regfile_n.sv - randomized self-checking bench for vliw_regfile_n against a register-array model
module tb_vliw_regfile_n;

    localparam int L = 3;
    localparam int W = 64;
    localparam int N = 16;
    localparam int A = 4;
`ifdef VLIW_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           flush;
    logic [L-1:0]   rd_valid, iss_valid, wr_en;
    logic [L*A-1:0] rd_src1, rd_src2, iss_dest, wr_dest;
    logic [L*W-1:0] wr_data;
    logic [L*W-1:0] src1_data, src2_data;
    logic [L*A-1:0] src1_idx, src2_idx;
    logic [L-1:0]   out_valid, hazard;

    vliw_regfile_n dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_flush     (flush),
        .i_rd_valid  (rd_valid),
        .i_rd_src1   (rd_src1),
        .i_rd_src2   (rd_src2),
        .i_iss_valid (iss_valid),
        .i_iss_dest  (iss_dest),
        .i_wr_en     (wr_en),
        .i_wr_dest   (wr_dest),
        .i_wr_data   (wr_data),
        .o_src1_data (src1_data),
        .o_src2_data (src2_data),
        .o_src1_idx  (src1_idx),
        .o_src2_idx  (src2_idx),
        .o_out_valid (out_valid),
        .o_hazard    (hazard)
    );

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [W-1:0] m_regs [N];
    bit           m_pend [N];
    logic [W-1:0] e_s1 [L];
    logic [W-1:0] e_s2 [L];
    logic [A-1:0] e_i1 [L];
    logic [A-1:0] e_i2 [L];
    bit           e_ov [L];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int fld(input logic [L*A-1:0] v, input int l);
        return int'(v[l*A +: A]);
    endfunction

    // Is register r being written by any lane this cycle?
    function automatic bit written(input int r);
        for (int j = 0; j < L; j++) if (wr_en[j] && fld(wr_dest, j) == r) return 1'b1;
        return 1'b0;
    endfunction

    // Value a read of r captures: old contents, or newest-lane write when bypass exists
    function automatic logic [W-1:0] read_val(input int r);
        logic [W-1:0] v = m_regs[r];
        if (BYP) for (int j = 0; j < L; j++)
            if (wr_en[j] && fld(wr_dest, j) == r) v = wr_data[j*W +: W];
        return v;
    endfunction

    function automatic bit busy(input int r);
        return m_pend[r] && !(BYP && written(r));
    endfunction

    task automatic model_reset();
        for (int r = 0; r < N; r++) begin m_regs[r] = '0; m_pend[r] = 1'b0; end
        for (int l = 0; l < L; l++) begin
            e_s1[l] = '0; e_s2[l] = '0; e_i1[l] = '0; e_i2[l] = '0; e_ov[l] = 1'b0;
        end
    endtask

    task automatic idle();
        flush = 1'b0; rd_valid = '0; iss_valid = '0; wr_en = '0;
        rd_src1 = '0; rd_src2 = '0; iss_dest = '0; wr_dest = '0; wr_data = '0;
    endtask

    task automatic check_outputs();
        for (int l = 0; l < L; l++) begin
            check($sformatf("out_valid[%0d]", l), 64'(out_valid[l]), 64'(e_ov[l]));
            check($sformatf("src1_data[%0d]", l), src1_data[l*W +: W], e_s1[l]);
            check($sformatf("src2_data[%0d]", l), src2_data[l*W +: W], e_s2[l]);
            check($sformatf("src1_idx[%0d]", l), 64'(src1_idx[l*A +: A]), 64'(e_i1[l]));
            check($sformatf("src2_idx[%0d]", l), 64'(src2_idx[l*A +: A]), 64'(e_i2[l]));
        end
    endtask

    // One clock: inputs already driven after a negedge
    task automatic cycle();
        #1;
        for (int l = 0; l < L; l++) begin
            bit h = rd_valid[l] && (busy(fld(rd_src1, l)) || busy(fld(rd_src2, l)));
            check($sformatf("hazard[%0d]", l), 64'(hazard[l]), 64'(h));
        end
        @(posedge clk);
        for (int l = 0; l < L; l++) begin
            if (rd_valid[l] && !flush) begin
                e_ov[l] = 1'b1;
                e_i1[l] = A'(fld(rd_src1, l));
                e_i2[l] = A'(fld(rd_src2, l));
                e_s1[l] = read_val(fld(rd_src1, l));
                e_s2[l] = read_val(fld(rd_src2, l));
            end else begin
                e_ov[l] = 1'b0;
            end
        end
        for (int j = 0; j < L; j++) if (wr_en[j]) begin
            m_regs[fld(wr_dest, j)] = wr_data[j*W +: W];
            m_pend[fld(wr_dest, j)] = 1'b0;
        end
        if (flush) begin
            for (int r = 0; r < N; r++) m_pend[r] = 1'b0;
        end else begin
            for (int j = 0; j < L; j++) if (iss_valid[j]) m_pend[fld(iss_dest, j)] = 1'b1;
        end
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        check("reset_hazard", 64'(hazard), 64'(0));
        rst_n = 1'b1;

        // Same-destination writes: lane 2 wins
        idle(); wr_en = 3'b101;
        wr_dest[0*A +: A] = 4'd3; wr_data[0*W +: W] = 64'h11;
        wr_dest[2*A +: A] = 4'd3; wr_data[2*W +: W] = 64'h22;
        cycle();
        idle(); rd_valid[0] = 1'b1; rd_src1[0 +: A] = 4'd3;
        cycle();
        check("t1_data", src1_data[0 +: W], 64'h22);
        check("t1_valid", 64'(out_valid[0]), 64'(1));

        // Issue then read: hazard until writeback
        idle(); iss_valid[1] = 1'b1; iss_dest[1*A +: A] = 4'd5;
        cycle();
        idle(); rd_valid[0] = 1'b1; rd_src1[0 +: A] = 4'd5;
        #1 check("t2_hazard_set", 64'(hazard[0]), 64'(1));
        cycle();
        idle(); wr_en[0] = 1'b1; wr_dest[0 +: A] = 4'd5; wr_data[0 +: W] = 64'hAB;
        cycle();
        idle(); rd_valid[0] = 1'b1; rd_src1[0 +: A] = 4'd5;
        #1 check("t2_hazard_clr", 64'(hazard[0]), 64'(0));
        cycle();
        check("t2_data", src1_data[0 +: W], 64'hAB);

        // Same-cycle write and read of a pending register
        idle(); iss_valid[0] = 1'b1; iss_dest[0 +: A] = 4'd7;
        cycle();
        idle(); wr_en[1] = 1'b1; wr_dest[1*A +: A] = 4'd7; wr_data[1*W +: W] = 64'h55;
        rd_valid[0] = 1'b1; rd_src1[0 +: A] = 4'd7;
        #1 check("t3_hazard", 64'(hazard[0]), BYP ? 64'(0) : 64'(1));
        cycle();
        check("t3_data", src1_data[0 +: W], BYP ? 64'h55 : 64'h0);

        // Issue beats writeback on the same register
        idle(); iss_valid[0] = 1'b1; iss_dest[0 +: A] = 4'd4;
        wr_en[1] = 1'b1; wr_dest[1*A +: A] = 4'd4; wr_data[1*W +: W] = 64'h44;
        cycle();
        idle(); rd_valid[0] = 1'b1; rd_src1[0 +: A] = 4'd4;
        #1 check("t4_hazard", 64'(hazard[0]), 64'(1));
        cycle();

        // Flush with all lanes reading and three registers pending; write still lands
        idle(); iss_valid = 3'b011; iss_dest[0 +: A] = 4'd1; iss_dest[1*A +: A] = 4'd2;
        cycle();
        idle(); flush = 1'b1; rd_valid = 3'b111;
        rd_src1[0 +: A] = 4'd1; rd_src1[1*A +: A] = 4'd2; rd_src1[2*A +: A] = 4'd4;
        wr_en[2] = 1'b1; wr_dest[2*A +: A] = 4'd9; wr_data[2*W +: W] = 64'h99;
        cycle();
        check("t5_valid", 64'(out_valid), 64'(0));
        idle(); rd_valid = 3'b111;
        rd_src1[0 +: A] = 4'd1; rd_src2[0 +: A] = 4'd2;
        rd_src1[1*A +: A] = 4'd4; rd_src1[2*A +: A] = 4'd9;
        #1 check("t5_hazard", 64'(hazard), 64'(0));
        cycle();
        check("t5_r9", src1_data[2*W +: W], 64'h99);

        // Randomized traffic against the model
        for (int c = 0; c < 300; c++) begin
            flush     = ($urandom_range(15) == 0);
            rd_valid  = L'($urandom);
            iss_valid = L'($urandom);
            wr_en     = L'($urandom);
            rd_src1   = (L*A)'($urandom);
            rd_src2   = (L*A)'($urandom);
            iss_dest  = (L*A)'($urandom);
            wr_dest   = ($urandom_range(3) == 0) ? {L{4'(c)}} : (L*A)'($urandom);
            for (int l = 0; l < L; l++) wr_data[l*W +: W] = {$urandom, $urandom};
            cycle();
        end

        // Asynchronous reset mid-stream with non-zero state
        idle(); wr_en[0] = 1'b1; wr_dest[0 +: A] = 4'd9; wr_data[0 +: W] = 64'h77;
        iss_valid[1] = 1'b1; iss_dest[1*A +: A] = 4'd6;
        rd_valid = 3'b111; rd_src1[0 +: A] = 4'd9;
        cycle();
        idle(); rd_valid = 3'b111; rd_src1[0 +: A] = 4'd6;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("t6_hazard", 64'(hazard), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        idle(); rd_valid[0] = 1'b1; rd_src1[0 +: A] = 4'd9;
        cycle();
        check("t6_r9", src1_data[0 +: W], 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vliw_regfile_n.md
# vliw_regfile_n

Parametrised multi-lane register file for the VLIW pipeline, replacing the fixed three-lane register file. It serves LANES issue lanes with two registered read ports and one write port per lane, and keeps a per-register pending scoreboard that flags read-after-write hazards to the fetch/decode side. It sits between fetch (source indices), writeback (write ports) and execute (operand data and indices), and is cleared by the execute-stage flush.

## Interface
- LANES, 3, number of issue lanes (1..8)
- WIDTH, 64, data width per register
- NREGS, 16, number of architectural registers (power of two, ≥2)
- AW, $clog2(NREGS), register index width (derived, not overridden)

- clock  in  1  rising-edge clock; the only clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  pipeline flush from execute
- rd_valid  in  LANES  lane i carries an instruction needing operands
- rd_src1 / rd_src2  in  LANES*AW  source indices, lane i at [i*AW +: AW]
- iss_valid  in  LANES  lane i issues a register-writing instruction
- iss_dest  in  LANES*AW  destination marked pending on issue
- wr_en  in  LANES  writeback write strobe per lane
- wr_dest  in  LANES*AW  writeback destination
- wr_data  in  LANES*WIDTH  writeback data
- src1_data / src2_data  out  LANES*WIDTH  registered operand data to execute
- src1_idx / src2_idx  out  LANES*AW  registered source indices, for execute forwarding
- out_valid  out  LANES  registered: operands in lane i are valid
- hazard  out  LANES  combinational: lane i reads a pending register

## Operation
- Storage: NREGS x WIDTH flops. All registers are writable; there is no hard-wired zero register.
- Write: at each clock edge, every lane with wr_en=1 writes wr_data to wr_dest.
  - Same wr_dest on several lanes: the highest lane index wins.
  - Writes proceed during flush, because older instructions still retire.
- Read: at each clock edge, each lane i with rd_valid[i]=1 and flush=0 captures the two operands and indices into its output flops and sets out_valid[i]=1.
  - Otherwise out_valid[i] becomes 0, and the data/index outputs hold their previous value.
- Scoreboard: pending[NREGS].
  - On each edge, bits are first cleared for every wr_en lane's wr_dest, then set for every iss_valid lane's iss_dest.
  - Set beats clear on the same register in the same cycle.
  - flush=1 clears all pending bits; iss_valid is ignored that cycle.
- hazard[i] = rd_valid[i] & (pending[rd_src1[i]] | pending[rd_src2[i]]), with the bypass exception under Configuration.
  - iss_dest in the same cycle never causes a hazard: intra-bundle dependencies are disallowed by the compiler.
- Reset (asynchronous, reset=0), mid-operation included:
  - all registers 0, all pending 0;
  - src*_data 0, src*_idx 0, out_valid 0;
  - hazard therefore reads 0 while reset is asserted.

## Timing
- Read latency: 1 cycle from rd_src to src*_data and out_valid.
- Write-to-storage: visible to a read issued in the cycle after wr_en.
- Same-cycle write and read of one register: behaviour depends on configuration (see below).
- hazard is combinational from rd_valid, rd_src* and the scoreboard, with no flop in its path.
- flush takes effect at the edge where it is sampled high: out_valid goes 0 the following cycle.

## Configuration
- VLIW_RF_BYPASS_EN defined: the write-to-read bypass is compiled in.
  - A read whose source equals an active same-cycle wr_dest captures that wr_data, using the highest-lane priority.
  - A pending bit being cleared by a same-cycle write does not raise hazard.
- VLIW_RF_BYPASS_EN undefined: reads capture pre-write storage contents.
  - hazard uses the scoreboard as registered, so a register being written this cycle still flags a hazard.

## Structure
- Shared package vliw_pkg holds:
  - the default constants VLIW_LANES, VLIW_WIDTH and VLIW_NREGS;
  - the lane-slicing helper functions.
- One sub-module, vliw_rf_scoreboard, holds the pending vector, the set/clear/flush logic and the hazard generation. The storage, write arbitration and read flops stay in the top module.

## Test plan
- Reset, then write lane0 r3=0x11 and lane2 r3=0x22 in the same cycle; read r3 next cycle -> src1_data=0x22, out_valid=1.
- Issue dest r5 on lane1, then lane0 reads r5 -> hazard[0]=1; after wr_en r5=0xAB, the next read gives hazard=0 and src data 0xAB.
- Same cycle: wr r7=0x55 and rd r7.
  - With the macro -> src_data=0x55 and hazard=0.
  - Without the macro -> old value and hazard=1.
- Same cycle: iss_valid r4 and wr_en r4 -> pending[r4]=1 afterwards, so the next read of r4 raises hazard.
- flush with rd_valid=all ones and three pending registers -> out_valid=0 next cycle, all pending cleared, and a concurrent write of r9=0x99 still lands.
- Assert reset mid-stream with non-zero state -> all outputs 0 immediately, asynchronously; reading r9 after release returns 0.
